// File: rtl/fp_cvt_arbiter_if.sv
// Request/response/unit bundle between requesters, the conversion arbiter and the shared FP unit.
// slave = arbiter side, master = requester/unit side.
interface fp_cvt_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [DATA_WIDTH-1:0]         unit_in;
    logic [DATA_WIDTH-1:0]         unit_out;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [NUM_REQ-1:0]            resp_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] resp_data;
    logic [3:0]                    inflight;

    modport slave (
        input  req_valid, req_data, unit_out, resp_ready,
        output req_ready, unit_in, resp_valid, resp_data, inflight
    );

    modport master (
        output req_valid, req_data, unit_out, resp_ready,
        input  req_ready, unit_in, resp_valid, resp_data, inflight
    );
endinterface

// File: rtl/fp_cvt_arbiter.sv
// Round-robin share of one LAT-cycle FP32 conversion unit; result lands in a one-entry slot LAT+1 cycles after grant.
// A requester is not re-granted while its operation is in flight or its slot is full, so slot backpressure never stalls the unit.
module fp_cvt_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LAT        = 2
) (
    input  logic            clk,
    input  logic            rst,
    fp_cvt_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);

    typedef logic [IW-1:0] idx_t;
    typedef struct packed {
        logic vld;
        idx_t idx;
    } tag_t;

    if (DATA_WIDTH != 32) begin : g_bad_width
        $fatal(1, "fp_cvt_arbiter: DATA_WIDTH must be 32");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $fatal(1, "fp_cvt_arbiter: NUM_REQ must be 2..8");
    end
    if (LAT < 1 || LAT > 8) begin : g_bad_lat
        $fatal(1, "fp_cvt_arbiter: LAT must be 1..8");
    end

    idx_t                               ptr_q, ptr_d;
    tag_t [LAT-1:0]                     tag_q, tag_d;
    logic [NUM_REQ-1:0]                 pending_q, pending_d;
    logic [NUM_REQ-1:0]                 resp_vld_q, resp_vld_d;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] resp_dat_q, resp_dat_d;
    logic [3:0]                         inflight_q, inflight_d;

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_dat;
    logic [NUM_REQ-1:0]                 elig;
    logic                               gnt_vld;
    idx_t                               win;
    tag_t                               cap;

    assign req_dat = bus.req_data;
    assign elig    = bus.req_valid & ~(pending_q | resp_vld_q);
    assign cap     = tag_q[LAT-1];

    always_comb begin : arb
        int cand;
        gnt_vld = 1'b0;
        win     = '0;
        cand    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr_q) + k) % NUM_REQ;
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                win     = idx_t'(cand);
            end
        end
        // Grant outputs must read zero while reset is held.
        if (rst) begin
            gnt_vld = 1'b0;
        end
    end

    always_comb begin : outs
        bus.req_ready = '0;
        bus.unit_in   = '0;
        if (gnt_vld) begin
            bus.req_ready[win] = 1'b1;
            bus.unit_in        = req_dat[win];
        end
    end

    always_comb begin : nxt
        int cnt;
        ptr_d      = ptr_q;
        pending_d  = pending_q;
        resp_vld_d = resp_vld_q & ~bus.resp_ready;
        resp_dat_d = resp_dat_q;
        tag_d[0]   = {gnt_vld, win};
        for (int s = 1; s < LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end
        if (cap.vld) begin
            resp_dat_d[cap.idx] = bus.unit_out;
            resp_vld_d[cap.idx] = 1'b1;
            pending_d[cap.idx]  = 1'b0;
        end
        if (gnt_vld) begin
            pending_d[win] = 1'b1;
            ptr_d          = (win == idx_t'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end
        cnt = 0;
        for (int s = 0; s < LAT; s++) begin
            cnt = cnt + int'(tag_d[s].vld);
        end
        inflight_d = 4'(cnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            tag_q      <= '0;
            pending_q  <= '0;
            resp_vld_q <= '0;
            resp_dat_q <= '0;
            inflight_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            tag_q      <= tag_d;
            pending_q  <= pending_d;
            resp_vld_q <= resp_vld_d;
            resp_dat_q <= resp_dat_d;
            inflight_q <= inflight_d;
        end
    end

    assign bus.resp_valid = resp_vld_q;
    assign bus.resp_data  = resp_dat_q;
    assign bus.inflight   = inflight_q;
endmodule

// File: tb/tb_fp_cvt_arbiter.sv
// Bench for fp_cvt_arbiter: ideal LAT-cycle itof unit, directed scenarios and a queue-based reference model.
module tb_fp_cvt_arbiter;
    localparam int N   = 4;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_cvt_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(32)) bus ();

    fp_cvt_arbiter #(.NUM_REQ(N), .DATA_WIDTH(32), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] itof(input logic [31:0] x);
        logic        s;
        logic [31:0] m;
        int          e;
        if (x == 32'd0) return 32'd0;
        s = x[31];
        m = s ? -x : x;
        e = 31;
        while (m[e] == 1'b0) e--;
        return {s, 8'(127 + e), 23'(m << (23 - e))};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] mag;
        mag = 32'($urandom_range(0, 24'hFFFFFF));
        return ($urandom_range(0, 1) == 1) ? -mag : mag;
    endfunction

    // Ideal shared unit: free-running LAT-stage pipeline.
    logic [31:0] upipe [LAT];
    always @(posedge clk) begin
        upipe[0] <= itof(bus.unit_in);
        for (int s = 1; s < LAT; s++) upipe[s] <= upipe[s-1];
    end
    assign bus.unit_out = upipe[LAT-1];

    // Reference model: ops in flight kept as a queue with due cycle.
    typedef struct {
        int          idx;
        logic [31:0] res;
        int          due;
    } op_t;

    op_t         m_fly[$];
    int          m_ptr;
    bit          m_full [N];
    logic [31:0] m_dat  [N];
    int          m_cyc;
    int          m_grant;
    int          exp_cap;
    logic [N-1:0]    exp_ready;
    logic [31:0]     exp_unit_in;
    logic [N-1:0]    exp_rvalid;
    logic [N*32-1:0] exp_rdata;
    logic [3:0]      exp_inflight;

    function automatic bit m_inflight(input int i);
        foreach (m_fly[q]) if (m_fly[q].idx == i) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_fly.delete();
        m_ptr = 0;
        m_cyc = 0;
        for (int i = 0; i < N; i++) begin
            m_full[i] = 1'b0;
            m_dat[i]  = 32'd0;
        end
    endtask

    task automatic model_eval();
        m_grant = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (m_grant < 0 && bus.req_valid[j] && !m_full[j] && !m_inflight(j)) m_grant = j;
        end
        exp_ready   = (m_grant >= 0) ? (N'(1) << m_grant) : '0;
        exp_unit_in = (m_grant >= 0) ? bus.req_data[m_grant*32 +: 32] : 32'd0;
        for (int i = 0; i < N; i++) begin
            exp_rvalid[i]          = m_full[i];
            exp_rdata[i*32 +: 32]  = m_dat[i];
        end
        exp_inflight = 4'(m_fly.size());
        exp_cap = (m_fly.size() > 0 && m_fly[0].due == m_cyc) ? m_fly[0].idx : -1;
    endtask

    task automatic model_advance();
        op_t o;
        for (int i = 0; i < N; i++) if (bus.resp_ready[i] && m_full[i]) m_full[i] = 1'b0;
        if (exp_cap >= 0) begin
            m_full[exp_cap] = 1'b1;
            m_dat[exp_cap]  = m_fly[0].res;
            void'(m_fly.pop_front());
        end
        if (m_grant >= 0) begin
            o.idx = m_grant;
            o.res = itof(bus.req_data[m_grant*32 +: 32]);
            o.due = m_cyc + LAT;
            m_fly.push_back(o);
            m_ptr = (m_grant + 1) % N;
        end
        m_cyc++;
    endtask

    task automatic tick();
        model_eval();
        model_advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.resp_ready = '0;
        bus.req_data   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.req_valid  = '1;
        bus.resp_ready = '1;
        bus.req_data   = {32'd4, 32'd3, 32'd2, 32'd1};
        @(negedge clk);
        #1;
        checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0000", bus.req_ready); end
        checks++; if (bus.unit_in !== 32'd0) begin errors++; $display("FAIL reset_unit_in got %h want 0", bus.unit_in); end
        checks++; if (bus.resp_valid !== 4'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0000", bus.resp_valid); end
        checks++; if (bus.resp_data !== 128'd0) begin errors++; $display("FAIL reset_resp_data got %h want 0", bus.resp_data); end
        checks++; if (bus.inflight !== 4'd0) begin errors++; $display("FAIL reset_inflight got %0d want 0", bus.inflight); end
        apply_reset();
    endtask

    task automatic test_basic();
        logic [3:0] want_inf [1:3];
        want_inf[1] = 4'd1; want_inf[2] = 4'd1; want_inf[3] = 4'd0;
        apply_reset();
        bus.req_valid = 4'b0001;
        bus.req_data  = {32'd0, 32'd0, 32'd0, 32'd1};
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL basic_grant got %b want 0001", bus.req_ready); end
        checks++; if (bus.unit_in !== 32'd1) begin errors++; $display("FAIL basic_unit_in got %h want 1", bus.unit_in); end
        tick();
        bus.req_valid = 4'b0000;
        for (int c = 1; c <= 3; c++) begin
            #1;
            checks++; if (bus.inflight !== want_inf[c]) begin errors++; $display("FAIL basic_inflight_c%0d got %0d want %0d", c, bus.inflight, want_inf[c]); end
            checks++; if (bus.resp_valid[0] !== (c == 3)) begin errors++; $display("FAIL basic_resp_valid_c%0d got %b want %b", c, bus.resp_valid[0], c == 3); end
            tick();
        end
        checks++; if (bus.resp_data[31:0] !== 32'h3F800000) begin errors++; $display("FAIL basic_resp_data got %h want 3f800000", bus.resp_data[31:0]); end
    endtask

    task automatic test_round_robin();
        logic [31:0] ops [N];
        ops[0] = -32'sd2; ops[1] = 32'd3; ops[2] = -32'sd7; ops[3] = 32'd100;
        apply_reset();
        bus.resp_ready = '1;
        bus.req_valid  = '1;
        for (int i = 0; i < N; i++) bus.req_data[i*32 +: 32] = ops[i];
        for (int c = 0; c < 16; c++) begin
            model_eval();
            #1;
            checks++; if (bus.req_ready !== (4'b0001 << (c % 4))) begin errors++; $display("FAIL rr_grant_c%0d got %b want %b", c, bus.req_ready, 4'b0001 << (c % 4)); end
            checks++; if (bus.unit_in !== ops[c % 4]) begin errors++; $display("FAIL rr_unit_in_c%0d got %h want %h", c, bus.unit_in, ops[c % 4]); end
            checks++; if (bus.resp_valid !== exp_rvalid) begin errors++; $display("FAIL rr_resp_valid_c%0d got %b want %b", c, bus.resp_valid, exp_rvalid); end
            for (int i = 0; i < N; i++) begin
                if (bus.resp_valid[i] === 1'b1) begin
                    checks++; if (bus.resp_data[i*32 +: 32] !== itof(ops[i])) begin errors++; $display("FAIL rr_resp_data%0d_c%0d got %h want %h", i, c, bus.resp_data[i*32 +: 32], itof(ops[i])); end
                end
            end
            if (c == 3) begin
                checks++; if (bus.resp_data[31:0] !== 32'hC0000000) begin errors++; $display("FAIL rr_neg2 got %h want c0000000", bus.resp_data[31:0]); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        bus.resp_ready = 4'b1011;
        bus.req_valid  = 4'b0100;
        bus.req_data[64 +: 32] = 32'd5;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL bp_first_grant got %b want 0100", bus.req_ready); end
        tick();
        for (int c = 1; c < 8; c++) begin
            #1;
            checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_blocked_c%0d got %b want 0000", c, bus.req_ready); end
            if (c >= 3) begin
                checks++; if (bus.resp_valid[2] !== 1'b1) begin errors++; $display("FAIL bp_slot_full_c%0d got %b want 1", c, bus.resp_valid[2]); end
                checks++; if (bus.resp_data[64 +: 32] !== 32'h40A00000) begin errors++; $display("FAIL bp_slot_data_c%0d got %h want 40a00000", c, bus.resp_data[64 +: 32]); end
            end
            tick();
        end
        bus.resp_ready[2] = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_pop_cycle got %b want 0000", bus.req_ready); end
        tick();
        bus.resp_ready[2] = 1'b0;
        bus.req_data[64 +: 32] = 32'd9;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL bp_regrant got %b want 0100", bus.req_ready); end
        checks++; if (bus.unit_in !== 32'd9) begin errors++; $display("FAIL bp_regrant_operand got %h want 9", bus.unit_in); end
        checks++; if (bus.resp_valid[2] !== 1'b0) begin errors++; $display("FAIL bp_popped got %b want 0", bus.resp_valid[2]); end
        checks++; if (bus.resp_data[64 +: 32] !== 32'h40A00000) begin errors++; $display("FAIL bp_data_hold got %h want 40a00000", bus.resp_data[64 +: 32]); end
        tick();
        bus.req_valid = '0;
    endtask

    task automatic test_wrap_hold();
        logic [3:0] vld  [6];
        logic [3:0] want [6];
        vld[0] = 4'b0100; want[0] = 4'b0100;
        vld[1] = 4'b0000; want[1] = 4'b0000;
        vld[2] = 4'b0000; want[2] = 4'b0000;
        vld[3] = 4'b0010; want[3] = 4'b0010;
        vld[4] = 4'b0000; want[4] = 4'b0000;
        vld[5] = 4'b1101; want[5] = 4'b0100;
        apply_reset();
        bus.resp_ready = '1;
        bus.req_data   = {32'd8, 32'd7, 32'd6, 32'd5};
        for (int c = 0; c < 6; c++) begin
            bus.req_valid = vld[c];
            #1;
            checks++; if (bus.req_ready !== want[c]) begin errors++; $display("FAIL wrap_grant_c%0d got %b want %b", c, bus.req_ready, want[c]); end
            tick();
        end
        bus.req_valid = '0;
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        bus.resp_ready = '1;
        bus.req_valid  = 4'b0001;
        bus.req_data   = {32'd0, 32'd13, 32'd11, 32'd7};
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_grant got %b want 0001", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        rst = 1'b1;
        #1;
        checks++; if (bus.inflight !== 4'd0) begin errors++; $display("FAIL rstmid_inflight got %0d want 0", bus.inflight); end
        checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL rstmid_req_ready got %b want 0000", bus.req_ready); end
        checks++; if (bus.unit_in !== 32'd0) begin errors++; $display("FAIL rstmid_unit_in got %h want 0", bus.unit_in); end
        checks++; if (bus.resp_valid !== 4'b0) begin errors++; $display("FAIL rstmid_resp_valid got %b want 0000", bus.resp_valid); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        bus.resp_ready = '0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (bus.resp_valid !== 4'b0) begin errors++; $display("FAIL rstmid_phantom_c%0d got %b want 0000", c, bus.resp_valid); end
            tick();
        end
        bus.req_valid = 4'b0110;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL rstmid_first_grant got %b want 0010", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        repeat (2) tick();
        #1;
        checks++; if (bus.resp_valid !== 4'b0010) begin errors++; $display("FAIL rstmid_fresh_valid got %b want 0010", bus.resp_valid); end
        checks++; if (bus.resp_data[32 +: 32] !== 32'h41300000) begin errors++; $display("FAIL rstmid_fresh_data got %h want 41300000", bus.resp_data[32 +: 32]); end
        tick();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            bus.req_valid  = 4'($urandom);
            bus.resp_ready = 4'($urandom) | 4'($urandom);
            for (int i = 0; i < N; i++) bus.req_data[i*32 +: 32] = rand_op();
            model_eval();
            #1;
            checks++; if (bus.req_ready !== exp_ready) begin errors++; $display("FAIL rnd_req_ready_c%0d got %b want %b", c, bus.req_ready, exp_ready); end
            checks++; if (bus.unit_in !== exp_unit_in) begin errors++; $display("FAIL rnd_unit_in_c%0d got %h want %h", c, bus.unit_in, exp_unit_in); end
            checks++; if (bus.resp_valid !== exp_rvalid) begin errors++; $display("FAIL rnd_resp_valid_c%0d got %b want %b", c, bus.resp_valid, exp_rvalid); end
            checks++; if (bus.resp_data !== exp_rdata) begin errors++; $display("FAIL rnd_resp_data_c%0d got %h want %h", c, bus.resp_data, exp_rdata); end
            checks++; if (bus.inflight !== exp_inflight) begin errors++; $display("FAIL rnd_inflight_c%0d got %0d want %0d", c, bus.inflight, exp_inflight); end
            if (exp_cap >= 0) begin
                checks++; if (bus.resp_valid[exp_cap] !== 1'b0) begin errors++; $display("FAIL rnd_capture_into_full_slot_c%0d slot %0d got %b want 0", c, exp_cap, bus.resp_valid[exp_cap]); end
            end
            tick();
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.resp_ready = '0;
        bus.req_data   = '0;
        test_reset();
        test_basic();
        test_round_robin();
        test_backpressure();
        test_wrap_hold();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_cvt_arbiter.md
# fp_cvt_arbiter

Round-robin arbiter that shares one pipelined fixed-latency FP32 conversion unit (e.g. int-to-float) among `NUM_REQ` requesters. Each requester has a valid/ready request channel and a valid/ready response channel. The block tags every issued operand, tracks it through the unit's `LAT`-cycle pipeline, and steers each result into that requester's one-entry response slot. It sits between the issue/dispatch logic and the shared conversion datapath in the fp32 core.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `DATA_WIDTH`, default 32: operand/result width; must equal 32, otherwise `$fatal` at elaboration.
- `LAT`, default 2: cycles from `unit_in` presentation to the matching `unit_out`, range 1..8.

Ports (clock and reset first):
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  `NUM_REQ`  per-requester request valid.
- `req_ready`  out  `NUM_REQ`  per-requester grant; one-hot or zero; combinational.
- `req_data`  in  `NUM_REQ*DATA_WIDTH`  operands; requester i occupies bits `[i*32 +: 32]`.
- `unit_in`  out  `DATA_WIDTH`  operand to the shared unit; combinational mux of the granted operand, 0 when idle.
- `unit_out`  in  `DATA_WIDTH`  result from the shared unit.
- `resp_valid`  out  `NUM_REQ`  registered; response slot i is full.
- `resp_ready`  in  `NUM_REQ`  requester i consumes its slot.
- `resp_data`  out  `NUM_REQ*DATA_WIDTH`  registered per-requester results, same packing as `req_data`.
- `inflight`  out  4  number of operations issued but not yet captured in a slot, 0..`LAT`.

## Operation
- Busy state:
  - `busy[i] = pending[i] | resp_valid[i]`.
  - `pending[i]` is set on grant to requester i and cleared when its result is captured.
  - Each requester has at most one outstanding operation.
- Eligibility: `elig[i] = req_valid[i] & ~busy[i]`.
- Round-robin grant:
  - Search starts at pointer `ptr` and wraps modulo `NUM_REQ`. The first eligible index wins.
  - `req_ready[win]` = 1; all other bits of `req_ready` are 0.
  - On a grant, `ptr <= win+1`, wrapping to 0 after `NUM_REQ-1`.
  - With no grant, `ptr` holds.
- Tag pipeline: a `LAT`-deep shift register of {valid, index}. Stage 0 loads {1, win} on a grant and {0, x} otherwise.
- Capture: when the last tag stage is valid with index k, `resp_data[k] <= unit_out`, `resp_valid[k] <= 1`, and `pending[k] <= 0`.
- Pop: `resp_ready[i] & resp_valid[i]` clears `resp_valid[i]`. `resp_data` holds its value.
- Capture and pop cannot target the same slot in the same cycle, because a slot is never granted while full. The bench asserts this.
- `inflight` = popcount of valid tag stages. Its update is registered alongside the tags.
- `unit_in` is driven with the operand only in the grant cycle. The unit is assumed free-running with no input valid of its own.

## Timing
- Reset values:
  - `ptr` = 0, all tags invalid, `pending` = 0.
  - `resp_valid` = 0, `resp_data` = 0, `inflight` = 0.
  - `req_ready` = 0 and `unit_in` = 0 while `rst` is high.
- Latency: a handshake in cycle t produces `resp_valid[i]` = 1 from cycle t+`LAT`+1. `unit_out` is sampled at the end of cycle t+`LAT`.
- Throughput: one issue per cycle across requesters. A single requester can issue at most once per `LAT`+1 cycles plus its pop cycle.
- Slot reuse: popping in cycle p makes the requester eligible in cycle p+1, not in p.
- `req_ready` never depends on `resp_ready` combinationally.
- Reset mid-operation:
  - All in-flight tags are dropped and unit results are ignored.
  - Responses held in slots are lost.
  - After reset deasserts, the first grant goes to the lowest eligible index.
- All valid: grants rotate 0,1,2,3,… subject to busy. A requester with `req_valid` held high is never starved for more than `NUM_REQ` issue opportunities.

## Test plan
- Basic issue and return:
  - Stimulus: reset, then `req_valid[0]`=1 with operand 1 at cycle 0. The bench models the unit as an ideal `LAT`=2 itof.
  - Required response: `req_ready[0]`=1 at cycle 0, `unit_in`=1, `resp_valid[0]` rises at cycle 3 with `resp_data[0]`=0x3F800000, and `inflight` is 1, 1, 0 over cycles 1–3.
- Round-robin fairness:
  - Stimulus: all 4 requesters valid continuously, `resp_ready` = all ones.
  - Required response: grant order is 0,1,2,3, then 0 again from cycle 4, then 1, 2, 3 as slots free. Each requester receives the correct result for its own operand (−2 → 0xC0000000).
- Slot backpressure:
  - Stimulus: requester 2 holds `resp_ready[2]`=0 after its first result; its operand is 5 → 0x40A00000.
  - Required response: `req_ready[2]` stays 0 while `resp_valid[2]`=1, and `resp_data[2]` stays stable. After the pop in cycle p, requester 2 is granted in cycle p+1.
- Wrap and pointer hold:
  - Stimulus: with `ptr`=3, only requester 1 is valid.
  - Required response: grant goes to 1 and the new `ptr` is 2. On idle cycles `ptr` holds.
- Reset mid-flight:
  - Stimulus: assert `rst` one cycle after a grant to requester 0.
  - Required response: all outputs go to their reset values immediately. No `resp_valid[0]` ever appears for the dropped operation. A fresh request after reset returns normally.
